// File: rtl/ptrfifo_ext_if.sv
// Handshake, data and status bundle for ptrfifo_ext. The master side drives the
// requests and write data; the slave side is the FIFO itself.
interface ptrfifo_ext_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 6
);
  logic             loaden;
  logic             unloaden;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic             dataout_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [DEPTH:0]   itemsinfifo;
  logic [DEPTH:0]   highwater;
  logic             overflow;
  logic             underflow;

  modport master (
    output loaden, unloaden, datain,
    input  dataout, dataout_valid, empty, full, almost_empty, almost_full,
           itemsinfifo, highwater, overflow, underflow
  );

  modport slave (
    input  loaden, unloaden, datain,
    output dataout, dataout_valid, empty, full, almost_empty, almost_full,
           itemsinfifo, highwater, overflow, underflow
  );
endinterface

// File: rtl/ptrfifo_ext.sv
// Pointer-based FIFO with full 2**DEPTH capacity, standard or FWFT read mode,
// threshold flags, sticky error flags, high-water mark and synchronous flush.
module ptrfifo_ext #(
  parameter int WIDTH         = 64,
  parameter int DEPTH         = 6,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = 2**DEPTH-4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  ptrfifo_ext_if.slave  bus
);
  localparam int             NWORDS = 2**DEPTH;
  localparam logic [DEPTH:0] CAP    = (DEPTH+1)'(NWORDS);
  localparam logic [DEPTH:0] AF     = (DEPTH+1)'(AFULL_THRESH);
  localparam logic [DEPTH:0] AE     = (DEPTH+1)'(AEMPTY_THRESH);
  localparam logic [DEPTH:0] ONE    = (DEPTH+1)'(1);

  logic [WIDTH-1:0] mem [NWORDS];
  logic [WIDTH-1:0] dout;
  logic [DEPTH:0]   wptr, wptr_q, rptr, count, hw;
  logic             dvalid, ovf, udf;
  logic             is_empty, is_full, acc_wr, acc_rd, stage;

  always_comb begin
    is_full  = (count == CAP);
    is_empty = (FWFT != 0) ? ~dvalid : (count == '0);
    acc_wr   = bus.loaden & ~is_full;
    acc_rd   = bus.unloaden & ~is_empty;
    // FWFT staging looks at the one-cycle-delayed write pointer, so a word
    // written at edge E reaches the output register at edge E+2.
    stage    = (FWFT != 0) && (wptr_q != rptr) && (~dvalid || acc_rd);
  end

  always_ff @(posedge clk) begin
    if (acc_wr) mem[wptr[DEPTH-1:0]] <= bus.datain;
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wptr   <= '0;
      wptr_q <= '0;
      rptr   <= '0;
      count  <= '0;
      hw     <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      dout   <= '0;
      dvalid <= 1'b0;
    end else begin
      if (acc_wr) wptr <= wptr + ONE;
      wptr_q <= wptr;

      unique case ({acc_wr, acc_rd})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase

      if (count > hw) hw <= count;
      if (bus.loaden && is_full)    ovf <= 1'b1;
      if (bus.unloaden && is_empty) udf <= 1'b1;

      if (FWFT != 0) begin
        if (stage) begin
          dout   <= mem[rptr[DEPTH-1:0]];
          dvalid <= 1'b1;
          rptr   <= rptr + ONE;
        end else if (acc_rd) begin
          dvalid <= 1'b0;
        end
      end else begin
        dvalid <= acc_rd;
        if (acc_rd) begin
          dout <= mem[rptr[DEPTH-1:0]];
          rptr <= rptr + ONE;
        end
      end
    end
  end

  always_comb begin
    bus.dataout       = dout;
    bus.dataout_valid = dvalid;
    bus.empty         = is_empty;
    bus.full          = is_full;
    bus.almost_empty  = (count <= AE);
    bus.almost_full   = (count >= AF);
    bus.itemsinfifo   = count;
    bus.highwater     = hw;
    bus.overflow      = ovf;
    bus.underflow     = udf;
  end
endmodule

// File: tb/tb_ptrfifo_ext.sv
// Scoreboard bench for ptrfifo_ext: one standard-mode and one FWFT instance,
// directed stimulus with expected read data queued when each read is issued.
module tb_ptrfifo_ext;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clear = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [63:0] d;
    int          due;
  } exp_t;

  exp_t        qs[$];
  logic [63:0] qf[$];

  ptrfifo_ext_if #(.WIDTH(64), .DEPTH(6)) s_if ();
  ptrfifo_ext_if #(.WIDTH(64), .DEPTH(6)) f_if ();

  ptrfifo_ext #(.WIDTH(64), .DEPTH(6), .FWFT(0)) u_std (
    .clk(clk), .rstn(rstn), .clear(clear), .bus(s_if));
  ptrfifo_ext #(.WIDTH(64), .DEPTH(6), .FWFT(1)) u_fw (
    .clk(clk), .rstn(rstn), .clear(clear), .bus(f_if));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Applies one cycle of inputs to the selected instance, returns #1 after the edge.
  task automatic step(input bit sel_f, input bit ld, input bit ul, input logic [63:0] d);
    s_if.loaden   = ld & ~sel_f;
    s_if.unloaden = ul & ~sel_f;
    f_if.loaden   = ld & sel_f;
    f_if.unloaden = ul & sel_f;
    s_if.datain   = d;
    f_if.datain   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_s(input logic [63:0] d);
    exp_t e;
    e.d   = d;
    e.due = cyc + 1;
    qs.push_back(e);
  endtask

  // Standard mode: every valid pulse must match the oldest queued read and its cycle.
  always @(negedge clk) begin
    if (s_if.dataout_valid) begin
      if (qs.size() == 0) begin
        chk("std_unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = qs.pop_front();
        chk("std_rdata", s_if.dataout, e.d);
        chk("std_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // FWFT: the head word is checked when it is about to be consumed.
  always @(negedge clk) begin
    if (f_if.unloaden && f_if.dataout_valid) begin
      if (qf.size() == 0) chk("fw_unexpected_pop", 64'd1, 64'd0);
      else chk("fw_rdata", f_if.dataout, qf.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] ev;
    s_if.loaden = 0; s_if.unloaden = 0; s_if.datain = '0;
    f_if.loaden = 0; f_if.unloaden = 0; f_if.datain = '0;

    // ---------------- standard mode ----------------
    rstn = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rstn = 1'b1;
    chk("rst_empty", s_if.empty, 1);
    chk("rst_full", s_if.full, 0);
    chk("rst_aempty", s_if.almost_empty, 1);
    chk("rst_afull", s_if.almost_full, 0);
    chk("rst_items", s_if.itemsinfifo, 0);
    chk("rst_hw", s_if.highwater, 0);
    chk("rst_ovf", s_if.overflow, 0);
    chk("rst_udf", s_if.underflow, 0);
    chk("rst_valid", s_if.dataout_valid, 0);
    chk("rst_dout", s_if.dataout, 0);

    for (int i = 0; i < 64; i++) begin
      step(0, 1, 0, 64'(i));
      n = i + 1;
      chk("fill_items", s_if.itemsinfifo, 64'(n));
      chk("fill_full", s_if.full, n == 64);
      chk("fill_afull", s_if.almost_full, n >= 60);
      chk("fill_aempty", s_if.almost_empty, n <= 4);
    end

    step(0, 1, 0, 64'd999);
    chk("ovf_set", s_if.overflow, 1);
    chk("ovf_items", s_if.itemsinfifo, 64);

    push_s(64'd0);
    step(0, 1, 1, 64'd555);
    chk("full_rw_items", s_if.itemsinfifo, 63);
    chk("full_rw_full", s_if.full, 0);
    chk("full_rw_ovf", s_if.overflow, 1);

    for (int i = 1; i < 64; i++) begin
      push_s(64'(i));
      step(0, 0, 1, 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("drain_empty", s_if.empty, 1);
    chk("drain_items", s_if.itemsinfifo, 0);
    chk("drain_hw", s_if.highwater, 64);
    chk("drain_sb", 64'(qs.size()), 0);

    step(0, 0, 1, 0);
    chk("udf_set", s_if.underflow, 1);
    chk("udf_items", s_if.itemsinfifo, 0);
    chk("udf_empty", s_if.empty, 1);
    step(0, 1, 0, 64'h77);
    push_s(64'h77);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("udf_sticky", s_if.underflow, 1);

    clear = 1'b1;
    step(0, 1, 0, 64'h88);
    clear = 1'b0;
    chk("clr_udf", s_if.underflow, 0);
    chk("clr_ovf", s_if.overflow, 0);
    chk("clr_items", s_if.itemsinfifo, 0);
    chk("clr_hw", s_if.highwater, 0);
    chk("clr_empty", s_if.empty, 1);

    for (int i = 0; i < 32; i++) step(0, 1, 0, 64'(1000 + i));
    chk("half_items", s_if.itemsinfifo, 32);
    for (int k = 0; k < 400; k++) begin
      ev = (k < 32) ? 64'(1000 + k) : 64'(2000 + k - 32);
      push_s(ev);
      step(0, 1, 1, 64'(2000 + k));
      chk("stream_items", s_if.itemsinfifo, 32);
    end
    for (int k = 400; k < 432; k++) begin
      push_s(64'(2000 + k - 32));
      step(0, 0, 1, 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("stream_empty", s_if.empty, 1);
    chk("stream_hw", s_if.highwater, 32);
    chk("stream_sb", 64'(qs.size()), 0);

    // ---------------- FWFT mode ----------------
    rstn = 1'b0;
    step(1, 0, 0, 0);
    rstn = 1'b1;
    chk("fw_rst_empty", f_if.empty, 1);
    chk("fw_rst_valid", f_if.dataout_valid, 0);

    step(1, 1, 0, 64'hA5);
    chk("fw_e0_items", f_if.itemsinfifo, 1);
    chk("fw_e0_valid", f_if.dataout_valid, 0);
    chk("fw_e0_empty", f_if.empty, 1);
    step(1, 0, 0, 0);
    chk("fw_e1_valid", f_if.dataout_valid, 0);
    chk("fw_e1_empty", f_if.empty, 1);
    step(1, 0, 0, 0);
    chk("fw_e2_valid", f_if.dataout_valid, 1);
    chk("fw_e2_dout", f_if.dataout, 64'hA5);
    chk("fw_e2_empty", f_if.empty, 0);
    qf.push_back(64'hA5);
    step(1, 0, 1, 0);
    chk("fw_pop_valid", f_if.dataout_valid, 0);
    chk("fw_pop_empty", f_if.empty, 1);
    chk("fw_pop_items", f_if.itemsinfifo, 0);

    for (int i = 0; i < 10; i++) step(1, 1, 0, 64'(3000 + i));
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("fw_burst_items", f_if.itemsinfifo, 10);
    for (int i = 0; i < 3; i++) begin
      qf.push_back(64'(3000 + i));
      step(1, 0, 1, 0);
    end
    chk("fw_b2b_items", f_if.itemsinfifo, 7);
    chk("fw_b2b_valid", f_if.dataout_valid, 1);
    chk("fw_b2b_dout", f_if.dataout, 64'd3003);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 64'(4000 + i));
    chk("fw_held10", f_if.itemsinfifo, 10);

    rstn = 1'b0;
    step(1, 1, 0, 64'hDEAD);
    rstn = 1'b1;
    chk("fw_mrst_items", f_if.itemsinfifo, 0);
    chk("fw_mrst_valid", f_if.dataout_valid, 0);
    chk("fw_mrst_dout", f_if.dataout, 0);
    chk("fw_mrst_empty", f_if.empty, 1);
    chk("fw_mrst_full", f_if.full, 0);
    chk("fw_mrst_aempty", f_if.almost_empty, 1);
    chk("fw_mrst_afull", f_if.almost_full, 0);
    chk("fw_mrst_hw", f_if.highwater, 0);
    chk("fw_mrst_ovf", f_if.overflow, 0);
    chk("fw_mrst_udf", f_if.underflow, 0);

    step(1, 1, 0, 64'hBEEF);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("fw_fresh_valid", f_if.dataout_valid, 1);
    chk("fw_fresh_dout", f_if.dataout, 64'hBEEF);
    qf.push_back(64'hBEEF);
    step(1, 0, 1, 0);
    chk("fw_fresh_empty", f_if.empty, 1);
    chk("fw_sb", 64'(qf.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
